wb_arbiter_scoreboard: RTL and testbench

- Parametrised successor to the register-file port controller.
- Owns the single register-file write port, shared between:
  - the in-order MW-stage writeback, which has priority;
  - NCH long-latency units (mult, div, ...), whose results are buffered in a FIFO.
- Keeps a busy scoreboard of destinations of in-flight long ops and raises stall for FD-stage RAW/WAW hazards.
- Sits between the MW/long-unit outputs and the regfile write inputs.

---
 rtl/wb_arbiter_scoreboard.sv | 228 ++++++++++++++++++++++
 tb/tb_wb_arbiter_scoreboard.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_scoreboard.sv
// wb_arbiter_scoreboard: arbitrates the single register-file write port
// between the MW-stage writeback, which has priority, and NCH long-latency
// result channels. Long-unit results are buffered in a FIFO. A busy
// scoreboard tracks in-flight long ops and raises a combinational FD stall.
// Optional build macro: WB_PROTOCOL_CHECK_EN enables the sticky err flag.
module wb_arbiter_scoreboard #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NCH   = 2,
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [AW-1:0]     pipe_rd,
    input  logic [DW-1:0]     pipe_data,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic [NCH-1:0]    lu_valid,
    input  logic [NCH*AW-1:0] lu_rd,
    input  logic [NCH*DW-1:0] lu_data,
    output logic [NCH-1:0]    lu_ready,
    input  logic [AW-1:0]     fd_rs_a,
    input  logic [AW-1:0]     fd_rs_b,
    input  logic [AW-1:0]     fd_rd,
    input  logic              fd_writes,
    output logic              stall,
    output logic              rf_we,
    output logic [AW-1:0]     rf_wd,
    output logic [DW-1:0]     rf_data,
    output logic              err
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FPW  = $clog2(DEPTH);
    localparam int CW   = FPW + 1;

    // Channel slices
    logic [AW-1:0]  ch_rd   [NCH];
    logic [DW-1:0]  ch_data [NCH];

    // FIFO state
    logic [AW-1:0]  fifo_rd_q   [DEPTH];
    logic [DW-1:0]  fifo_data_q [DEPTH];
    logic [FPW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FPW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // Arbitration state
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW:0]    cand;
    logic [PW:0]    rr_sum;
    logic [PW-1:0]  grant;
    logic           any_valid;
    logic [AW-1:0]  grant_rd;
    logic [DW-1:0]  grant_data;

    // Scoreboard and write port
    logic [NREG-1:0] busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_wd_q, rf_wd_d;
    logic [DW-1:0]   rf_data_q, rf_data_d;
    logic            rf_src_fifo_q, rf_src_fifo_d;

    logic            full;
    logic            push;
    logic            pop;
    logic            pipe_sel;
    logic [AW-1:0]   head_rd;
    logic [DW-1:0]   head_data;

    // Unpack the flat channel buses into per-channel arrays
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_rd[i]   = lu_rd[i*AW +: AW];
            ch_data[i] = lu_data[i*DW +: DW];
        end
    end

    // Round-robin grant: first valid channel searched upward from rr_ptr
    always_comb begin
        cand      = '0;
        grant     = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NCH)) begin
                cand = cand - (PW+1)'(NCH);
            end
            if (!any_valid && lu_valid[cand[PW-1:0]]) begin
                any_valid = 1'b1;
                grant     = cand[PW-1:0];
            end
        end
        grant_rd   = ch_rd[grant];
        grant_data = ch_data[grant];
    end

    assign full      = (count_q == CW'(DEPTH));
    assign push      = any_valid && !full;
    assign pipe_sel  = pipe_we && (pipe_rd != '0);
    assign pop       = !pipe_sel && (count_q != '0);
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign lu_ready  = push ? (NCH'(1) << grant) : '0;

    // Next-state for FIFO pointers, occupancy and round-robin pointer
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FPW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FPW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        rr_sum   = {1'b0, grant} + (PW+1)'(1);
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (rr_sum >= (PW+1)'(NCH)) ? '0 : rr_sum[PW-1:0];
        end
    end

    // Write-port selection: pipe first, then FIFO head; rd 0 heads are dropped
    always_comb begin
        rf_we_d       = 1'b0;
        rf_wd_d       = rf_wd_q;
        rf_data_d     = rf_data_q;
        rf_src_fifo_d = 1'b0;
        if (pipe_sel) begin
            rf_we_d   = 1'b1;
            rf_wd_d   = pipe_rd;
            rf_data_d = pipe_data;
        end else if (pop && (head_rd != '0)) begin
            rf_we_d       = 1'b1;
            rf_wd_d       = head_rd;
            rf_data_d     = head_data;
            rf_src_fifo_d = 1'b1;
        end
    end

    // Scoreboard: clear after a FIFO-sourced write lands, then set (set wins)
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q && rf_src_fifo_q) begin
            busy_d[rf_wd_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control and scoreboard registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rr_ptr_q      <= '0;
            busy_q        <= '0;
            rf_we_q       <= 1'b0;
            rf_wd_q       <= '0;
            rf_data_q     <= '0;
            rf_src_fifo_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= busy_d;
            rf_we_q       <= rf_we_d;
            rf_wd_q       <= rf_wd_d;
            rf_data_q     <= rf_data_d;
            rf_src_fifo_q <= rf_src_fifo_d;
        end
    end

    // FIFO storage; occupancy is tracked by count_q so no reset is needed
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= grant_rd;
            fifo_data_q[wr_ptr_q] <= grant_data;
        end
    end

    // Combinational FD hazard detection; busy_q[0] is held at 0
    always_comb begin
        stall = busy_q[fd_rs_a] | busy_q[fd_rs_b] | (fd_writes & busy_q[fd_rd]);
    end

    assign rf_we   = rf_we_q;
    assign rf_wd   = rf_wd_q;
    assign rf_data = rf_data_q;

`ifdef WB_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    // Sticky protocol error on busy-register misuse or unexpected results
    always_comb begin
        err_d = err_q;
        if (pipe_sel && busy_q[pipe_rd]) begin
            err_d = 1'b1;
        end
        if (issue_valid && (issue_rd != '0) && busy_q[issue_rd]) begin
            err_d = 1'b1;
        end
        if (push && (grant_rd != '0) && !busy_q[grant_rd]) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// Directed bench for wb_arbiter_scoreboard: a stall vector table plus
// hand-written multi-cycle sequences for arbitration, priority, reset and
// the optional WB_PROTOCOL_CHECK_EN error flag.
module tb_wb_arbiter_scoreboard;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              pipe_we;
    logic [AW-1:0]     pipe_rd;
    logic [DW-1:0]     pipe_data;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic [NCH-1:0]    lu_valid;
    logic [NCH*AW-1:0] lu_rd;
    logic [NCH*DW-1:0] lu_data;
    logic [NCH-1:0]    lu_ready;
    logic [AW-1:0]     fd_rs_a;
    logic [AW-1:0]     fd_rs_b;
    logic [AW-1:0]     fd_rd;
    logic              fd_writes;
    logic              stall;
    logic              rf_we;
    logic [AW-1:0]     rf_wd;
    logic [DW-1:0]     rf_data;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] rs_a;
        logic [AW-1:0] rs_b;
        logic [AW-1:0] rd;
        logic          writes;
        logic          exp_stall;
    } stall_vec_t;

    stall_vec_t svec[9];

    wb_arbiter_scoreboard #(
        .AW(AW), .DW(DW), .NCH(NCH), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .fd_rs_a(fd_rs_a), .fd_rs_b(fd_rs_b), .fd_rd(fd_rd), .fd_writes(fd_writes),
        .stall(stall),
        .rf_we(rf_we), .rf_wd(rf_wd), .rf_data(rf_data),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [AW-1:0] rd,
                          input logic [DW-1:0] d);
        lu_valid[ch]         = v;
        lu_rd[ch*AW +: AW]   = rd;
        lu_data[ch*DW +: DW] = d;
    endtask

    task automatic idle();
        pipe_we     = 1'b0;
        pipe_rd     = '0;
        pipe_data   = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        lu_valid    = '0;
        lu_rd       = '0;
        lu_data     = '0;
        fd_rs_a     = '0;
        fd_rs_b     = '0;
        fd_rd       = '0;
        fd_writes   = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    // Test 4 stimulus: per-cycle channel valids/rds and the expected grant
    logic [NCH-1:0] t4_valid [8];
    logic [AW-1:0]  t4_rd0   [8];
    logic [AW-1:0]  t4_rd1   [8];
    logic [NCH-1:0] t4_ready [8];
    logic [AW-1:0]  t4_wd    [8];

    initial begin
        svec[0] = '{rs_a: 5'd0,  rs_b: 5'd0,  rd: 5'd0,  writes: 1'b1, exp_stall: 1'b0};
        svec[1] = '{rs_a: 5'd8,  rs_b: 5'd0,  rd: 5'd0,  writes: 1'b0, exp_stall: 1'b1};
        svec[2] = '{rs_a: 5'd0,  rs_b: 5'd8,  rd: 5'd0,  writes: 1'b0, exp_stall: 1'b1};
        svec[3] = '{rs_a: 5'd0,  rs_b: 5'd0,  rd: 5'd8,  writes: 1'b1, exp_stall: 1'b1};
        svec[4] = '{rs_a: 5'd0,  rs_b: 5'd0,  rd: 5'd8,  writes: 1'b0, exp_stall: 1'b0};
        svec[5] = '{rs_a: 5'd13, rs_b: 5'd1,  rd: 5'd2,  writes: 1'b1, exp_stall: 1'b1};
        svec[6] = '{rs_a: 5'd1,  rs_b: 5'd2,  rd: 5'd3,  writes: 1'b1, exp_stall: 1'b0};
        svec[7] = '{rs_a: 5'd0,  rs_b: 5'd0,  rd: 5'd13, writes: 1'b0, exp_stall: 1'b0};
        svec[8] = '{rs_a: 5'd12, rs_b: 5'd12, rd: 5'd12, writes: 1'b1, exp_stall: 1'b0};

        t4_valid = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
        t4_rd0   = '{5'd20, 5'd22, 5'd22, 5'd24, 5'd24, 5'd24, 5'd24, 5'd0};
        t4_rd1   = '{5'd21, 5'd21, 5'd23, 5'd23, 5'd25, 5'd25, 5'd25, 5'd25};
        t4_ready = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
        t4_wd    = '{5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  5'd20, 5'd21, 5'd22};

        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_wd", rf_wd, 0);
        chk("reset_rf_data", rf_data, 0);
        chk("reset_err", err, 0);
        chk("reset_stall", stall, 0);
        reset = 1'b0;
        tick();

        // ---- Test 2: single long op, rd 7, result 6 cycles after issue
        fd_rs_b = 5'd7;
        settle();
        chk("t2_stall_pre", stall, 0);
        issue(5'd7);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t2_stall_wait", stall, 1);
            tick();
        end
        set_ch(0, 1'b1, 5'd7, 32'h0000_002A);
        settle();
        chk("t2_ready", lu_ready, 2'b01);
        tick();
        lu_valid = '0;
        settle();
        chk("t2_we_push", rf_we, 0);
        chk("t2_stall_push", stall, 1);
        tick();
        chk("t2_we", rf_we, 1);
        chk("t2_wd", rf_wd, 7);
        chk("t2_data", rf_data, 32'h2A);
        chk("t2_stall_wr", stall, 1);
        tick();
        chk("t2_we_after", rf_we, 0);
        chk("t2_wd_hold", rf_wd, 7);
        chk("t2_stall_clr", stall, 0);
        chk("t2_err", err, 0);
        fd_rs_b = '0;

        // ---- Test 3: pipe priority over a queued result (rr_ptr now 1)
        fd_rs_a = 5'd10;
        issue(5'd10);
        set_ch(1, 1'b1, 5'd10, 32'h55);
        settle();
        chk("t3_ready", lu_ready, 2'b10);
        chk("t3_stall", stall, 1);
        tick();
        lu_valid = '0;
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
        tick();
        chk("t3_wd3", rf_wd, 3);
        chk("t3_data3", rf_data, 32'h33);
        pipe_rd = 5'd4; pipe_data = 32'h44;
        tick();
        chk("t3_wd4", rf_wd, 4);
        pipe_rd = 5'd9; pipe_data = 32'h99;
        tick();
        chk("t3_wd9", rf_wd, 9);
        chk("t3_we9", rf_we, 1);
        pipe_we = 1'b0;
        settle();
        chk("t3_stall_q", stall, 1);
        tick();
        chk("t3_we_fifo", rf_we, 1);
        chk("t3_wd_fifo", rf_wd, 10);
        chk("t3_data_fifo", rf_data, 32'h55);
        chk("t3_stall_wr", stall, 1);
        tick();
        chk("t3_stall_clr", stall, 0);
        chk("t3_we_off", rf_we, 0);
        fd_rs_a = '0;

        // ---- Test 4: round-robin, back-pressure at DEPTH, drain (rr_ptr now 0)
        for (int r = 20; r <= 25; r++) issue(5'(r));
        pipe_rd = 5'd1; pipe_data = 32'h11;
        for (int i = 0; i < 8; i++) begin
            pipe_we = (i < 5);
            set_ch(0, t4_valid[i][0], t4_rd0[i], 32'h100 + 32'(t4_rd0[i]));
            set_ch(1, t4_valid[i][1], t4_rd1[i], 32'h100 + 32'(t4_rd1[i]));
            settle();
            chk("t4_ready", lu_ready, t4_ready[i]);
            tick();
            chk("t4_we", rf_we, 1);
            chk("t4_wd", rf_wd, t4_wd[i]);
        end
        lu_valid = '0;
        pipe_we  = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t4_drain_wd", rf_wd, 23 + j);
            chk("t4_drain_data", rf_data, 32'h100 + 23 + j);
        end
        tick();
        chk("t4_drain_end", rf_we, 0);
        chk("t4_err", err, 0);

        // ---- Test 5: register 0 and same-edge set/clear (rr_ptr now 0)
        fd_rs_a = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        settle();
        chk("t5_r0_stall_a", stall, 0);
        tick();
        issue_valid = 1'b0;
        settle();
        chk("t5_r0_stall_b", stall, 0);
        issue(5'd12);
        set_ch(0, 1'b1, 5'd12, 32'h0C);
        settle();
        chk("t5_ready", lu_ready, 2'b01);
        tick();
        lu_valid = '0;
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
        tick();
        chk("t5_r0_pipe_we", rf_we, 1);
        chk("t5_r0_pipe_wd", rf_wd, 12);
        chk("t5_r0_pipe_data", rf_data, 32'h0C);
        pipe_we = 1'b0;
        fd_rs_a = 5'd12;
        issue(5'd12);
        settle();
        chk("t5_setwins", stall, 1);
        chk("t5_we_off", rf_we, 0);
        tick();
        chk("t5_setwins_hold", stall, 1);

        // ---- Test 1: reset mid-stream with 3 queued results and busy[5]
        fd_rs_a = '0;
        issue(5'd5);
        pipe_we = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
        set_ch(0, 1'b1, 5'd5, 32'h5);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t1_fill_ready", lu_ready, 2'b01);
            tick();
        end
        lu_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("t1_async_we", rf_we, 0);
        chk("t1_async_wd", rf_wd, 0);
        chk("t1_async_data", rf_data, 0);
        pipe_we = 1'b0;
        fd_rs_a = 5'd5;
        #1;
        reset = 1'b0;
        tick();
        chk("t1_we", rf_we, 0);
        chk("t1_stall", stall, 0);
        chk("t1_err", err, 0);
        set_ch(0, 1'b1, 5'd0, 32'h0);
        set_ch(1, 1'b1, 5'd0, 32'h0);
        settle();
        chk("t1_ready_rr", lu_ready, 2'b01);
        lu_valid = '0;
        tick();
        chk("t1_fifo_empty", rf_we, 0);
        fd_rs_a = '0;

        // ---- Stall table with busy = {8, 13}
        issue(5'd8);
        issue(5'd13);
        for (int i = 0; i < 9; i++) begin
            fd_rs_a   = svec[i].rs_a;
            fd_rs_b   = svec[i].rs_b;
            fd_rd     = svec[i].rd;
            fd_writes = svec[i].writes;
            settle();
            chk("stall_vec", stall, svec[i].exp_stall);
        end

        // ---- Test 6: second issue to busy rd 8
        chk("t6_err_pre", err, 0);
        issue(5'd8);
        settle();
`ifdef WB_PROTOCOL_CHECK_EN
        chk("t6_err_set", err, 1);
        repeat (3) tick();
        chk("t6_err_sticky", err, 1);
        reset = 1'b1;
        #1;
        chk("t6_err_reset", err, 0);
        reset = 1'b0;
`else
        chk("t6_err_tied", err, 0);
        repeat (3) tick();
        chk("t6_err_tied_later", err, 0);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
